cpu_multicycle: RTL and testbench

CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

---
 rtl/cpu_multicycle.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multicycle RV32I subset core (LUI, AUIPC, JAL, JALR, branches, LW, SW,
// OP-IMM, OP) with a single shared request/ready memory port.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   mem_req    out  memory transaction request (FETCH and MEM states only)
//   mem_we     out  1 = write (SW), 0 = read
//   mem_addr   out  word-aligned address
//   mem_wdata  out  store data
//   mem_ready  in   transaction completes this cycle
//   mem_rdata  in   read data, valid with mem_req & mem_ready
//   pc_out     out  PC of the instruction in progress
//   cpu_out    out  last value written to a nonzero architectural register
//   retire     out  one-cycle pulse in WB
//   halted     out  core parked in HALT
//
// Optional feature: define CPU_MULTICYCLE_EBREAK_HALT_EN to make EBREAK park the core in
// HALT after it retires. Without it EBREAK behaves like any unknown opcode and halted is 0.

module cpu_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] cpu_out,
  output logic        retire,
  output logic        halted
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;

  localparam logic [5:0] NumRegsW = 6'(NUM_REGS);

`ifdef CPU_MULTICYCLE_EBREAK_HALT_EN
  localparam logic [31:0] InstrEbreak = 32'h0010_0073;
`endif

  state_e      r_state;
  state_e      w_state_next;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [31:0] r_imm;
  logic [31:0] r_alu;
  logic [31:0] r_npc;
  logic [31:0] r_ldata;
  logic [31:0] r_cpu_out;
  logic [31:0] r_regs [32];

  // Instruction fields, decoded from the latched IR.
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_f3;
  logic        w_is_lw;
  logic        w_is_sw;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_is_lw  = (w_opcode == OpLoad)  && (w_f3 == 3'b010);
  assign w_is_sw  = (w_opcode == OpStore) && (w_f3 == 3'b010);

  // Register reads: x0 and registers beyond NUM_REGS read as zero.
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;

  assign w_rs1_val = ((w_rs1 != 5'd0) && ({1'b0, w_rs1} < NumRegsW)) ? r_regs[w_rs1] : 32'h0;
  assign w_rs2_val = ((w_rs2 != 5'd0) && ({1'b0, w_rs2} < NumRegsW)) ? r_regs[w_rs2] : 32'h0;

  // Immediate generation.
  logic [31:0] w_imm;

  always_comb begin
    w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
    case (w_opcode)
      OpLui, OpAuipc: w_imm = {r_ir[31:12], 12'h000};
      OpJal:          w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
      OpBranch:       w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      OpStore:        w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      default:        w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
    endcase
  end

  // ALU shared by OP and OP-IMM.
  logic [31:0] w_alu_b;
  logic [4:0]  w_shamt;
  logic        w_sub;
  logic [31:0] w_alu;

  assign w_alu_b = (w_opcode == OpOp) ? r_op2 : r_imm;
  assign w_shamt = w_alu_b[4:0];
  // ir[30] selects SUB only for register-register ADD; ADDI has no subtract form.
  assign w_sub   = r_ir[30] && (w_opcode == OpOp);

  always_comb begin
    w_alu = 32'h0;
    case (w_f3)
      3'b000: w_alu = w_sub ? (r_op1 - w_alu_b) : (r_op1 + w_alu_b);
      3'b001: w_alu = r_op1 << w_shamt;
      3'b010: w_alu = {31'h0, $signed(r_op1) < $signed(w_alu_b)};
      3'b011: w_alu = {31'h0, r_op1 < w_alu_b};
      3'b100: w_alu = r_op1 ^ w_alu_b;
      3'b101: w_alu = r_ir[30] ? 32'($signed(r_op1) >>> w_shamt) : (r_op1 >> w_shamt);
      3'b110: w_alu = r_op1 | w_alu_b;
      3'b111: w_alu = r_op1 & w_alu_b;
      default: w_alu = 32'h0;
    endcase
  end

  // Branch decision.
  logic w_taken;

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000:  w_taken = (r_op1 == r_op2);
      3'b001:  w_taken = (r_op1 != r_op2);
      3'b100:  w_taken = ($signed(r_op1) < $signed(r_op2));
      3'b101:  w_taken = ($signed(r_op1) >= $signed(r_op2));
      3'b110:  w_taken = (r_op1 < r_op2);
      3'b111:  w_taken = (r_op1 >= r_op2);
      default: w_taken = 1'b0;
    endcase
  end

  // EXECUTE result (register value or memory address) and next PC.
  logic [31:0] w_res;
  logic [31:0] w_npc;

  always_comb begin
    w_res = 32'h0;
    w_npc = r_pc + 32'd4;
    case (w_opcode)
      OpLui:   w_res = r_imm;
      OpAuipc: w_res = r_pc + r_imm;
      OpJal: begin
        w_res = r_pc + 32'd4;
        w_npc = r_pc + r_imm;
      end
      OpJalr: begin
        w_res = r_pc + 32'd4;
        w_npc = (r_op1 + r_imm) & ~32'd1;
      end
      OpBranch: begin
        if (w_taken) begin
          w_npc = r_pc + r_imm;
        end
      end
      OpLoad, OpStore: w_res = r_op1 + r_imm;
      OpImm, OpOp:     w_res = w_alu;
      default: ;
    endcase
    w_npc[1:0] = 2'b00;
  end

  // Write-back selection.
  logic        w_writes_rd;
  logic        w_rd_we;
  logic [31:0] w_wb_data;

  always_comb begin
    w_writes_rd = 1'b0;
    case (w_opcode)
      OpLui, OpAuipc, OpJal, OpJalr, OpImm, OpOp: w_writes_rd = 1'b1;
      OpLoad:  w_writes_rd = w_is_lw;
      default: w_writes_rd = 1'b0;
    endcase
  end

  assign w_rd_we   = w_writes_rd && (w_rd != 5'd0) && ({1'b0, w_rd} < NumRegsW);
  assign w_wb_data = w_is_lw ? r_ldata : r_alu;

  // FSM next state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StFetch:   if (mem_ready) w_state_next = StDecode;
      StDecode:  w_state_next = StExecute;
      StExecute: w_state_next = (w_is_lw || w_is_sw) ? StMem : StWb;
      StMem:     if (mem_ready) w_state_next = StWb;
`ifdef CPU_MULTICYCLE_EBREAK_HALT_EN
      StWb:      w_state_next = (r_ir == InstrEbreak) ? StHalt : StFetch;
`else
      StWb:      w_state_next = StFetch;
`endif
      StHalt:    w_state_next = StHalt;
      default:   w_state_next = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_ir      <= 32'h0;
      r_op1     <= 32'h0;
      r_op2     <= 32'h0;
      r_imm     <= 32'h0;
      r_alu     <= 32'h0;
      r_npc     <= 32'h0;
      r_ldata   <= 32'h0;
      r_cpu_out <= 32'h0;
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'h0;
      end
    end else begin
      case (r_state)
        StFetch: begin
          if (mem_ready) begin
            r_ir <= mem_rdata;
          end
        end
        StDecode: begin
          r_op1 <= w_rs1_val;
          r_op2 <= w_rs2_val;
          r_imm <= w_imm;
        end
        StExecute: begin
          r_alu <= w_res;
          r_npc <= w_npc;
        end
        StMem: begin
          if (mem_ready && w_is_lw) begin
            r_ldata <= mem_rdata;
          end
        end
        StWb: begin
          r_pc <= r_npc;
          if (w_rd_we) begin
            r_regs[w_rd] <= w_wb_data;
            r_cpu_out    <= w_wb_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs. mem_req is gated by rst so it drops the moment reset is asserted.
  assign mem_req   = rst && ((r_state == StFetch) || (r_state == StMem));
  assign mem_we    = (r_state == StMem) && w_is_sw;
  assign mem_addr  = (r_state == StMem) ? {r_alu[31:2], 2'b00} : {r_pc[31:2], 2'b00};
  assign mem_wdata = r_op2;
  assign pc_out    = r_pc;
  assign cpu_out   = r_cpu_out;
  assign retire    = (r_state == StWb);

`ifdef CPU_MULTICYCLE_EBREAK_HALT_EN
  assign halted = (r_state == StHalt);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_multicycle.sv
// Scoreboard bench for cpu_multicycle: each program pushes expected retire records
// (PC after, cpu_out after, cycles since previous retire); a monitor pops one per retire.
module tb_cpu_multicycle;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] pc_out;
  logic [31:0] cpu_out;
  logic        retire;
  logic        halted;

  cpu_multicycle #(
    .RESET_PC(32'h0000_0000),
    .NUM_REGS(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .pc_out   (pc_out),
    .cpu_out  (cpu_out),
    .retire   (retire),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] out;
    int          lat;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc;
  int          last_ret = 0;
  logic [31:0] mem [256];
  logic [31:0] slow_addr = 32'h0000_0100;
  int          slow_wait = 0;
  int          wcnt = 0;

  localparam logic [6:0] OpLui = 7'b0110111, OpAuipc = 7'b0010111, OpImm = 7'b0010011;
  localparam logic [6:0] OpJalr = 7'b1100111, OpLoad = 7'b0000011;
  localparam logic [31:0] Ebreak = 32'h0010_0073;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Instruction encoders.
  function automatic logic [31:0] f_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] f_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] f_s(int imm, int rs2, int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] f_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] f_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] f_u(int imm20, int rd, logic [6:0] op);
    return {imm20[19:0], rd[4:0], op};
  endfunction

  task automatic push(input string name, input logic [31:0] pc, input logic [31:0] out,
                      input int lat);
    exp_t e;
    e.name = name; e.pc = pc; e.out = out; e.lat = lat;
    q.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic start();
    repeat (2) @(negedge clk);
    last_ret = 0;
    rst = 1'b1;
  endtask

  // Wait for the scoreboard to drain, then park the core in reset at once.
  task automatic run_phase(input string name, input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d retires pending, required 0", name, q.size());
      q.delete();
    end
    rst = 1'b0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Memory model: slow_addr stalls slow_wait request cycles; everything else is zero-wait.
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      mem_ready = (mem_addr == slow_addr) ? (wcnt >= slow_wait) : 1'b1;
      mem_rdata = mem[mem_addr[9:2]];
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
    end
  end

  always @(posedge clk) begin
    if (rst !== 1'b1 || mem_req !== 1'b1) begin
      wcnt = 0;
    end else if (mem_ready) begin
      wcnt = 0;
      if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
    end else begin
      wcnt++;
    end
  end

  // Retire monitor.
  initial begin
    int   ret_cyc;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && retire === 1'b1) begin
        ret_cyc = cyc + 1;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_retire: pc_out=%h, required no retire", pc_out);
        end else begin
          e = q.pop_front();
          check({e.name, "_pc"}, pc_out, e.pc);
          check({e.name, "_out"}, cpu_out, e.out);
          check({e.name, "_lat"}, 32'(ret_cyc - last_ret), 32'(e.lat));
          last_ret = ret_cyc;
        end
      end
    end
  end

  // Handshake hold monitor: a stalled request must keep its attributes.
  initial begin
    logic        ps;
    logic [31:0] s_addr, s_wdata;
    logic        s_we;
    ps = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst !== 1'b1) begin
        ps = 1'b0;
      end else begin
        if (ps) begin
          check("hold_req", {31'h0, mem_req}, 32'h1);
          check("hold_addr", mem_addr, s_addr);
          check("hold_we", {31'h0, mem_we}, {31'h0, s_we});
          if (s_we) check("hold_wdata", mem_wdata, s_wdata);
        end
        ps = mem_req && !mem_ready;
        s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    #12;
    check("reset_mem_req", {31'h0, mem_req}, 32'h0);
    check("reset_pc", pc_out, 32'h0);
    check("reset_out", cpu_out, 32'h0);
    check("reset_retire", {31'h0, retire}, 32'h0);
    check("reset_halted", {31'h0, halted}, 32'h0);

    // Phase A: ALU, x0, x16+ discard, unknown opcode, EBREAK.
    clear_mem();
    mem[0]  = f_i(5, 0, 0, 1, OpImm);          // ADDI x1,x0,5
    mem[1]  = f_i(-3, 0, 0, 2, OpImm);         // ADDI x2,x0,-3
    mem[2]  = f_r(32, 2, 1, 0, 3);             // SUB x3,x1,x2
    mem[3]  = f_r(0, 1, 2, 2, 4);              // SLT x4,x2,x1
    mem[4]  = f_r(0, 1, 2, 3, 4);              // SLTU x4,x2,x1
    mem[5]  = f_i(32'h401, 2, 5, 5, OpImm);    // SRAI x5,x2,1
    mem[6]  = f_i(28, 2, 5, 5, OpImm);         // SRLI x5,x2,28
    mem[7]  = f_i(3, 1, 1, 6, OpImm);          // SLLI x6,x1,3
    mem[8]  = f_i(32'hFF, 6, 4, 6, OpImm);     // XORI x6,x6,0xFF
    mem[9]  = f_u(32'h12345, 7, OpLui);        // LUI x7,0x12345
    mem[10] = f_u(1, 7, OpAuipc);              // AUIPC x7,1
    mem[11] = f_j(8, 8);                       // JAL x8,+8
    mem[13] = f_i(9, 0, 0, 0, OpImm);          // ADDI x0,x0,9
    mem[14] = f_i(0, 0, 0, 9, OpImm);          // ADDI x9,x0,0
    mem[15] = f_i(9, 0, 0, 20, OpImm);         // ADDI x20,x0,9
    mem[16] = f_i(1, 20, 0, 10, OpImm);        // ADDI x10,x20,1
    mem[17] = 32'h0000_000B;                   // unknown opcode
    mem[18] = Ebreak;
    mem[19] = f_i(2, 1, 0, 11, OpImm);         // ADDI x11,x1,2
    mem[20] = f_r(0, 1, 3, 6, 12);             // OR x12,x3,x1
    mem[21] = f_r(0, 2, 6, 7, 12);             // AND x12,x6,x2
    mem[22] = f_r(32, 1, 2, 5, 13);            // SRA x13,x2,x1
    push("addi", 32'h04, 32'h5, 4);
    push("addi_neg", 32'h08, 32'hFFFF_FFFD, 4);
    push("sub", 32'h0C, 32'h8, 4);
    push("slt", 32'h10, 32'h1, 4);
    push("sltu", 32'h14, 32'h0, 4);
    push("srai", 32'h18, 32'hFFFF_FFFE, 4);
    push("srli", 32'h1C, 32'hF, 4);
    push("slli", 32'h20, 32'h28, 4);
    push("xori", 32'h24, 32'hD7, 4);
    push("lui", 32'h28, 32'h1234_5000, 4);
    push("auipc", 32'h2C, 32'h1028, 4);
    push("jal", 32'h34, 32'h30, 4);
    push("x0_write", 32'h38, 32'h30, 4);
    push("x0_read", 32'h3C, 32'h0, 4);
    push("x20_write", 32'h40, 32'h0, 4);
    push("x20_read", 32'h44, 32'h1, 4);
    push("unknown", 32'h48, 32'h1, 4);
    push("ebreak", 32'h4C, 32'h1, 4);
`ifdef CPU_MULTICYCLE_EBREAK_HALT_EN
    start();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    check("ebreak_drained", 32'(q.size()), 32'h0);
    repeat (3) @(negedge clk);
    check("halted", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("halt_no_req", {31'h0, mem_req}, 32'h0);
    end
    q.delete();
    rst = 1'b0;
`else
    push("after_ebreak", 32'h50, 32'h7, 4);
    push("or", 32'h54, 32'hD, 4);
    push("and", 32'h58, 32'hD5, 4);
    push("sra", 32'h5C, 32'hFFFF_FFFF, 4);
    start();
    run_phase("alu", 200);
    check("halted_tied", {31'h0, halted}, 32'h0);
`endif

    // Phase B: branches and JALR.
    clear_mem();
    mem[0]  = f_i(-1, 0, 0, 1, OpImm);         // ADDI x1,x0,-1
    mem[1]  = f_i(1, 0, 0, 2, OpImm);          // ADDI x2,x0,1
    mem[2]  = f_j(32'h18, 0);                  // JAL x0,+0x18 -> 0x20
    mem[8]  = f_b(16, 2, 1, 4);                // 0x20 BLT x1,x2,+16
    mem[12] = f_b(16, 2, 1, 6);                // 0x30 BLTU x1,x2,+16
    mem[13] = f_b(8, 2, 2, 0);                 // 0x34 BEQ x2,x2,+8
    mem[15] = f_b(8, 1, 1, 1);                 // 0x3C BNE x1,x1,+8
    mem[16] = f_b(8, 1, 2, 5);                 // 0x40 BGE x2,x1,+8
    mem[17] = f_i(2, 0, 0, 6, OpImm);          // 0x44 ADDI x6,x0,2
    mem[18] = f_b(-8, 1, 2, 7);                // 0x48 BGEU x2,x1,-8
    mem[19] = f_i(32'h41, 0, 0, 1, OpImm);     // 0x4C ADDI x1,x0,0x41
    mem[20] = f_i(3, 1, 0, 5, OpJalr);         // 0x50 JALR x5,x1,3
    push("b_x1", 32'h04, 32'hFFFF_FFFF, 4);
    push("b_x2", 32'h08, 32'h1, 4);
    push("b_jal_x0", 32'h20, 32'h1, 4);
    push("blt_taken", 32'h30, 32'h1, 4);
    push("bltu_not", 32'h34, 32'h1, 4);
    push("beq_taken", 32'h3C, 32'h1, 4);
    push("bne_not", 32'h40, 32'h1, 4);
    push("bge_taken", 32'h48, 32'h1, 4);
    push("bgeu_not", 32'h4C, 32'h1, 4);
    push("b_x1_41", 32'h50, 32'h41, 4);
    push("jalr", 32'h44, 32'h54, 4);
    push("jalr_tgt", 32'h48, 32'h2, 4);
    start();
    run_phase("branch", 200);

    // Phase C: SW/LW and a stalled load.
    clear_mem();
    mem[0]  = f_j(32'h40, 0);                  // JAL x0,+0x40
    mem[16] = f_i(7, 0, 0, 1, OpImm);          // 0x40 ADDI x1,x0,7
    mem[17] = f_s(8, 1, 0);                    // 0x44 SW x1,8(x0)
    mem[18] = f_i(8, 0, 2, 3, OpLoad);         // 0x48 LW x3,8(x0)
    mem[19] = f_i(32'h100, 0, 0, 4, OpImm);    // 0x4C ADDI x4,x0,0x100
    mem[20] = f_i(0, 4, 2, 2, OpLoad);         // 0x50 LW x2,0(x4)
    mem[21] = f_s(4, 2, 4);                    // 0x54 SW x2,4(x4)
    mem[64] = 32'hDEAD_BEEF;
    slow_wait = 3;
    push("c_jal", 32'h40, 32'h0, 4);
    push("c_addi", 32'h44, 32'h7, 4);
    push("sw", 32'h48, 32'h7, 5);
    push("lw", 32'h4C, 32'h7, 5);
    push("c_base", 32'h50, 32'h100, 4);
    push("lw_slow", 32'h54, 32'hDEAD_BEEF, 8);
    push("sw2", 32'h58, 32'hDEAD_BEEF, 5);
    start();
    run_phase("mem", 200);
    check("sw_mem8", mem[2], 32'h7);
    check("sw_mem104", mem[65], 32'hDEAD_BEEF);

    // Phase D: reset asserted while a load is stalled in MEM.
    clear_mem();
    mem[0]  = f_i(32'h100, 0, 0, 4, OpImm);    // ADDI x4,x0,0x100
    mem[1]  = f_i(0, 4, 2, 2, OpLoad);         // LW x2,0(x4)
    mem[64] = 32'hDEAD_BEEF;
    slow_wait = 50;
    push("d_base", 32'h04, 32'h100, 4);
    start();
    for (int i = 0; i < 40 && !(mem_req && mem_addr == 32'h100); i++) @(negedge clk);
    check("d_stall_addr", mem_addr, 32'h100);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("d_rst_req", {31'h0, mem_req}, 32'h0);
    check("d_rst_pc", pc_out, 32'h0);
    check("d_rst_out", cpu_out, 32'h0);
    check("d_rst_retire", {31'h0, retire}, 32'h0);
    slow_wait = 0;
    push("d_refetch", 32'h04, 32'h100, 4);
    push("d_lw", 32'h08, 32'hDEAD_BEEF, 5);
    start();
    run_phase("reset_mid", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
